// File: rtl/cmd_dispatch_pkg.sv
// Purpose : shared constants for cmd_dispatch: command codes, status codes,
//           FSM state encoding, per-channel reset defaults and the FIFO entry layout.
// Latency / backpressure: not applicable (package only).
package cmd_dispatch_pkg;

    // Host command codes
    localparam logic [15:0] CMD_START_RUN      = 16'd1;
    localparam logic [15:0] CMD_STOP_RUN       = 16'd2;
    localparam logic [15:0] CMD_SET_TRIG_MODE  = 16'd3;
    localparam logic [15:0] CMD_SET_TRIG_EDGE  = 16'd4;
    localparam logic [15:0] CMD_SET_TRIG_FREQU = 16'd5;
    localparam logic [15:0] CMD_SET_WAVE_SIZE  = 16'd6;
    localparam logic [15:0] CMD_READ_REG       = 16'd8;

    // Completion status codes
    localparam logic [15:0] STS_OK       = 16'd0;
    localparam logic [15:0] STS_BAD_CMD  = 16'd1;
    localparam logic [15:0] STS_BAD_CH   = 16'd2;
    localparam logic [15:0] STS_BAD_FREQ = 16'd3;
    localparam logic [15:0] STS_RANGE    = 16'd4;

    // FSM state encoding. The range check is folded into the exit of the
    // divider states, so it never occupies a cycle of its own.
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_DIV_CYC = 3'd2;
    localparam logic [2:0] S_DIV_PLS = 3'd3;
    localparam logic [2:0] S_COMMIT  = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    // Per-channel reset defaults
    localparam logic [15:0] WAVE_SIZE_RST = 16'd128;
    localparam logic [2:0]  WAVE_RATE_RST = 3'd1;
    localparam int          CYCLE_RST     = 100000;
    localparam int          PULSE_RST     = 100;

    // One queued host command
    typedef struct packed {
        logic [15:0] code;
        logic [3:0]  ch;
        logic        bcast;
        logic [31:0] param;
    } cmd_t;

    // Commands that exist in every build
    function automatic logic is_base_cmd(input logic [15:0] c);
        return (c >= CMD_START_RUN) && (c <= CMD_SET_WAVE_SIZE);
    endfunction

endpackage

// File: rtl/seq_div.sv
// Purpose : unsigned 32-bit restoring divider, one quotient bit per cycle.
// Latency : o_done pulses 33 cycles after i_start; o_quotient holds until next start.
// Backpressure: none; i_start while busy restarts the division.
// Ports   : i_clk, i_rst_n, i_start, i_dividend, i_divisor -> o_busy, o_done, o_quotient
module seq_div (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_quotient
);

    logic [31:0] r_rem;
    logic [31:0] r_quo;     // shifts dividend out at the top, quotient in at the bottom
    logic [31:0] r_dvs;
    logic [5:0]  r_cnt;
    logic        r_busy;
    logic        r_done;

    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;

    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    // Remainder < divisor, so a borrow shows up in bit 32 exactly when shift < divisor.
    assign w_ge    = ~w_diff[32];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem  <= '0;
                r_quo  <= i_dividend;
                r_dvs  <= i_divisor;
                r_cnt  <= 6'd32;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_ge ? w_diff[31:0] : w_shift[31:0];
                r_quo <= {r_quo[30:0], w_ge};
                r_cnt <= r_cnt - 6'd1;
                if (r_cnt == 6'd1) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_quotient = r_quo;

endmodule

// File: rtl/cmd_dispatch.sv
// Purpose : queues host commands and applies them to NUM_CH pulser/acquisition channel registers.
// Latency : pop to o_finish 3 cycles; SET_TRIG_FREQU 36 or 69 cycles (one or two divisions).
// Backpressure: o_cmd_ready drops while the FIFO_DEPTH-entry command FIFO is full.
// Ports   : i_cmd_* host command in (valid/ready); o_run/o_outmode/o_outnegedge/o_waveRawSize/
//           o_waveRate/o_cycle/o_pulse channel registers (ch k in slice k); o_finish/o_finish_code/
//           o_rsp_data completion report. Build option: CMD_DISPATCH_READBACK_EN enables READ_REG (8).
module cmd_dispatch
    import cmd_dispatch_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_HZ     = 100000000,
    parameter int CYCLE_W    = 20,
    parameter int PULSE_W    = 12
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic [15:0]                i_cmd,
    input  logic [3:0]                 i_cmd_ch,
    input  logic                       i_cmd_bcast,
    input  logic [31:0]                i_cmd_param,
    output logic [NUM_CH-1:0]          o_run,
    output logic [NUM_CH-1:0]          o_outmode,
    output logic [NUM_CH-1:0]          o_outnegedge,
    output logic [NUM_CH*16-1:0]       o_waveRawSize,
    output logic [NUM_CH*3-1:0]        o_waveRate,
    output logic [NUM_CH*CYCLE_W-1:0]  o_cycle,
    output logic [NUM_CH*PULSE_W-1:0]  o_pulse,
    output logic                       o_finish,
    output logic [15:0]                o_finish_code,
    output logic [31:0]                o_rsp_data
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [31:0] CYC_MAX = 32'((64'd1 << CYCLE_W) - 64'd1);
    localparam logic [31:0] PLS_MAX = 32'((64'd1 << PULSE_W) - 64'd1);

    // ---------------- command FIFO ----------------
    cmd_t        r_fifo [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    cmd_t        w_in;

    logic [2:0]  r_state;

    assign w_in    = '{code: i_cmd, ch: i_cmd_ch, bcast: i_cmd_bcast, param: i_cmd_param};
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    // Same slot, opposite lap: the writer is a full lap ahead.
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = i_cmd_valid && !w_full;
    assign w_pop   = (r_state == S_IDLE) && !w_empty;
    assign o_cmd_ready = !w_full;

    always_ff @(posedge i_clk) begin
        if (w_push) r_fifo[r_wr_ptr[AW-1:0]] <= w_in;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // ---------------- channel registers ----------------
    logic [NUM_CH-1:0]  r_run;
    logic [NUM_CH-1:0]  r_outmode;
    logic [NUM_CH-1:0]  r_outneg;
    logic [15:0]        r_wsize  [NUM_CH];
    logic [2:0]         r_wrate  [NUM_CH];
    logic [CYCLE_W-1:0] r_cycle  [NUM_CH];
    logic [PULSE_W-1:0] r_pulse  [NUM_CH];

    // ---------------- command in flight ----------------
    cmd_t        r_cur;
    logic [15:0] r_status;
    logic [31:0] r_rsp;
    logic [31:0] r_cyc_q;
    logic [31:0] r_pls_q;
    logic        r_finish;
    logic [15:0] r_finish_code;
    logic [31:0] r_rsp_data;

    logic [15:0]       w_freq;
    logic [15:0]       w_pulse_ns;
    logic              w_ch_ok;
    logic              w_known;
    logic              w_is_read;
    logic [15:0]       w_dec_status;
    logic [31:0]       w_rd_data;
    logic [NUM_CH-1:0] w_hit;

    assign w_freq     = r_cur.param[15:0];
    assign w_pulse_ns = r_cur.param[31:16];
    assign w_ch_ok    = r_cur.bcast || (32'(r_cur.ch) < 32'(NUM_CH));

    always_comb begin
        w_hit = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_hit[k] = r_cur.bcast || (r_cur.ch == 4'(k));
        end
    end

`ifdef CMD_DISPATCH_READBACK_EN
    logic [3:0] w_rd_ch;

    assign w_is_read = (r_cur.code == CMD_READ_REG);
    assign w_known   = is_base_cmd(r_cur.code) || (w_is_read && (r_cur.param[2:0] <= 3'd3));
    // A broadcast read has no single target; it reports channel 0.
    assign w_rd_ch   = r_cur.bcast ? 4'd0 : r_cur.ch;

    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_rd_ch == 4'(k)) begin
                case (r_cur.param[2:0])
                    3'd0:    w_rd_data = {29'd0, r_run[k], r_outmode[k], r_outneg[k]};
                    3'd1:    w_rd_data = {13'd0, r_wrate[k], r_wsize[k]};
                    3'd2:    w_rd_data = 32'(r_cycle[k]);
                    3'd3:    w_rd_data = 32'(r_pulse[k]);
                    default: w_rd_data = '0;
                endcase
            end
        end
    end
`else
    assign w_is_read = 1'b0;
    assign w_known   = is_base_cmd(r_cur.code);
    assign w_rd_data = '0;
`endif

    always_comb begin
        if (!w_known)
            w_dec_status = STS_BAD_CMD;
        else if (!w_ch_ok)
            w_dec_status = STS_BAD_CH;
        else if ((r_cur.code == CMD_SET_TRIG_FREQU) && (w_freq == 16'd0))
            w_dec_status = STS_BAD_FREQ;
        else
            w_dec_status = STS_OK;
    end

    // ---------------- shared divider ----------------
    // DECODE launches cycle = CLK_HZ / freq; the DIV_CYC exit launches pulse = ns / 10.
    logic        w_div_start;
    logic        w_div_busy;
    logic        w_div_done;
    logic [31:0] w_div_a;
    logic [31:0] w_div_b;
    logic [31:0] w_quo;

    assign w_div_a = (r_state == S_DECODE) ? 32'(CLK_HZ) : {16'd0, w_pulse_ns};
    assign w_div_b = (r_state == S_DECODE) ? {16'd0, w_freq} : 32'd10;
    assign w_div_start = !w_div_busy &&
        (((r_state == S_DECODE) && (r_cur.code == CMD_SET_TRIG_FREQU) && (w_dec_status == STS_OK)) ||
         ((r_state == S_DIV_CYC) && w_div_done && (w_pulse_ns != 16'd0)));

    seq_div u_div (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (w_div_start),
        .i_dividend (w_div_a),
        .i_divisor  (w_div_b),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_quo)
    );

    // ---------------- control FSM ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_cur         <= '0;
            r_status      <= STS_OK;
            r_rsp         <= '0;
            r_cyc_q       <= '0;
            r_pls_q       <= '0;
            r_finish      <= 1'b0;
            r_finish_code <= '0;
            r_rsp_data    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_cur   <= r_fifo[r_rd_ptr[AW-1:0]];
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_status <= w_dec_status;
                    r_rsp    <= (w_is_read && (w_dec_status == STS_OK)) ? w_rd_data : 32'd0;
                    if ((r_cur.code == CMD_SET_TRIG_FREQU) && (w_dec_status == STS_OK))
                        r_state <= S_DIV_CYC;
                    else
                        r_state <= S_COMMIT;
                end
                S_DIV_CYC: begin
                    if (w_div_done) begin
                        r_cyc_q <= w_quo;
                        if (w_pulse_ns == 16'd0) begin
                            // Pulse untouched, so only the new period needs to fit.
                            r_status <= (w_quo > CYC_MAX) ? STS_RANGE : STS_OK;
                            r_state  <= S_COMMIT;
                        end else begin
                            r_state  <= S_DIV_PLS;
                        end
                    end
                end
                S_DIV_PLS: begin
                    if (w_div_done) begin
                        r_pls_q  <= w_quo;
                        r_status <= ((r_cyc_q > CYC_MAX) || (w_quo > PLS_MAX) || (w_quo >= r_cyc_q))
                                    ? STS_RANGE : STS_OK;
                        r_state  <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_finish      <= 1'b1;
                    r_finish_code <= r_status;
                    r_rsp_data    <= r_rsp;
                    r_state       <= S_DONE;
                end
                S_DONE: begin
                    r_finish <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Channel writes happen only in COMMIT and only for a clean status.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run     <= '0;
            r_outmode <= '0;
            r_outneg  <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_wsize[k] <= WAVE_SIZE_RST;
                r_wrate[k] <= WAVE_RATE_RST;
                r_cycle[k] <= CYCLE_W'(CYCLE_RST);
                r_pulse[k] <= PULSE_W'(PULSE_RST);
            end
        end else if ((r_state == S_COMMIT) && (r_status == STS_OK)) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_hit[k]) begin
                    case (r_cur.code)
                        CMD_START_RUN:     r_run[k]     <= 1'b1;
                        CMD_STOP_RUN:      r_run[k]     <= 1'b0;
                        CMD_SET_TRIG_MODE: r_outmode[k] <= r_cur.param[0];
                        CMD_SET_TRIG_EDGE: r_outneg[k]  <= r_cur.param[0];
                        CMD_SET_TRIG_FREQU: begin
                            r_cycle[k] <= r_cyc_q[CYCLE_W-1:0];
                            if (w_pulse_ns != 16'd0) r_pulse[k] <= r_pls_q[PULSE_W-1:0];
                        end
                        CMD_SET_WAVE_SIZE: begin
                            r_wsize[k] <= r_cur.param[15:0];
                            r_wrate[k] <= r_cur.param[18:16];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // ---------------- outputs ----------------
    assign o_run         = r_run;
    assign o_outmode     = r_outmode;
    assign o_outnegedge  = r_outneg;
    assign o_finish      = r_finish;
    assign o_finish_code = r_finish_code;
    assign o_rsp_data    = r_rsp_data;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_out
        assign o_waveRawSize[16*k +: 16]    = r_wsize[k];
        assign o_waveRate[3*k +: 3]         = r_wrate[k];
        assign o_cycle[CYCLE_W*k +: CYCLE_W] = r_cycle[k];
        assign o_pulse[PULSE_W*k +: PULSE_W] = r_pulse[k];
    end

endmodule

// File: tb/tb_cmd_dispatch.sv
// Purpose : self-checking bench for cmd_dispatch: directed cases plus random commands
//           checked against a queue-based behavioural model (result, timing, registers).
// Latency / backpressure: drives valid/ready, holds a command until accepted.
module tb_cmd_dispatch;

    localparam int NUM_CH  = 4;
    localparam int CYCLE_W = 20;
    localparam int PULSE_W = 12;
    localparam int CLK_HZ  = 100000000;

    logic                      i_clk;
    logic                      i_rst_n;
    logic                      i_cmd_valid;
    logic                      o_cmd_ready;
    logic [15:0]               i_cmd;
    logic [3:0]                i_cmd_ch;
    logic                      i_cmd_bcast;
    logic [31:0]               i_cmd_param;
    logic [NUM_CH-1:0]         o_run;
    logic [NUM_CH-1:0]         o_outmode;
    logic [NUM_CH-1:0]         o_outnegedge;
    logic [NUM_CH*16-1:0]      o_waveRawSize;
    logic [NUM_CH*3-1:0]       o_waveRate;
    logic [NUM_CH*CYCLE_W-1:0] o_cycle;
    logic [NUM_CH*PULSE_W-1:0] o_pulse;
    logic                      o_finish;
    logic [15:0]               o_finish_code;
    logic [31:0]               o_rsp_data;

    cmd_dispatch #(
        .NUM_CH(NUM_CH), .FIFO_DEPTH(4), .CLK_HZ(CLK_HZ), .CYCLE_W(CYCLE_W), .PULSE_W(PULSE_W)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd(i_cmd), .i_cmd_ch(i_cmd_ch), .i_cmd_bcast(i_cmd_bcast), .i_cmd_param(i_cmd_param),
        .o_run(o_run), .o_outmode(o_outmode), .o_outnegedge(o_outnegedge),
        .o_waveRawSize(o_waveRawSize), .o_waveRate(o_waveRate),
        .o_cycle(o_cycle), .o_pulse(o_pulse),
        .o_finish(o_finish), .o_finish_code(o_finish_code), .o_rsp_data(o_rsp_data)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, cmp=%0d err=%0d", 0, 1);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          cmd;
        int          ch;
        bit          bc;
        logic [31:0] param;
        longint      push_cyc;
    } acc_t;

    acc_t   acc_q[$];
    longint cyc = 0;
    longint fprev = 0;
    bit     saw_stall = 0;

    bit m_run  [NUM_CH];
    bit m_mode [NUM_CH];
    bit m_neg  [NUM_CH];
    int m_size [NUM_CH];
    int m_rate [NUM_CH];
    int m_cycle[NUM_CH];
    int m_pulse[NUM_CH];

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_run[k] = 0; m_mode[k] = 0; m_neg[k] = 0;
            m_size[k] = 128; m_rate[k] = 1; m_cycle[k] = 100000; m_pulse[k] = 100;
        end
    endtask

    // Result of one command from the command table; also applies it to the model.
    task automatic model_exec(input acc_t a, output int code, output int lat);
        int     freq;
        int     ns;
        longint cq;
        longint pq;
        freq = int'(a.param[15:0]);
        ns   = int'(a.param[31:16]);
        lat  = 3;
        cq   = 0;
        pq   = 0;
        if (a.cmd < 1 || a.cmd > 6)            code = 1;
        else if (!a.bc && a.ch >= NUM_CH)      code = 2;
        else if (a.cmd == 5 && freq == 0)      code = 3;
        else begin
            code = 0;
            if (a.cmd == 5) begin
                cq  = CLK_HZ / freq;
                lat = 3 + 33;
                if (cq > (1 << CYCLE_W) - 1) code = 4;
                if (ns != 0) begin
                    lat = 3 + 33 + 33;
                    pq  = ns / 10;
                    if (pq > (1 << PULSE_W) - 1 || pq >= cq) code = 4;
                end
            end
            if (code == 0) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (a.bc || a.ch == k) begin
                        case (a.cmd)
                            1: m_run[k]  = 1;
                            2: m_run[k]  = 0;
                            3: m_mode[k] = a.param[0];
                            4: m_neg[k]  = a.param[0];
                            5: begin
                                m_cycle[k] = int'(cq);
                                if (ns != 0) m_pulse[k] = int'(pq);
                            end
                            default: begin
                                m_size[k] = int'(a.param[15:0]);
                                m_rate[k] = int'(a.param[18:16]);
                            end
                        endcase
                    end
                end
            end
        end
    endtask

    task automatic check_regs();
        for (int k = 0; k < NUM_CH; k++) begin
            chk("run",       o_run[k],                         m_run[k]);
            chk("outmode",   o_outmode[k],                     m_mode[k]);
            chk("outnegedge", o_outnegedge[k],                 m_neg[k]);
            chk("waveRawSize", o_waveRawSize[16*k +: 16],      m_size[k]);
            chk("waveRate",  o_waveRate[3*k +: 3],             m_rate[k]);
            chk("cycle",     o_cycle[CYCLE_W*k +: CYCLE_W],    m_cycle[k]);
            chk("pulse",     o_pulse[PULSE_W*k +: PULSE_W],    m_pulse[k]);
        end
    endtask

    // Monitor: records accepted commands and checks every completion in order.
    always @(negedge i_clk) begin
        acc_t   a;
        int     code;
        int     lat;
        longint pop;
        if (!i_rst_n) begin
            acc_q.delete();
            model_reset();
            fprev = cyc;
        end else begin
            if (o_finish) begin
                if (acc_q.size() == 0) begin
                    chk("spurious_finish", 1, 0);
                end else begin
                    a = acc_q.pop_front();
                    model_exec(a, code, lat);
                    // Dispatcher pops the cycle after the push, or after the previous DONE.
                    pop = (a.push_cyc + 1 > fprev + 1) ? a.push_cyc + 1 : fprev + 1;
                    chk("latency", cyc, pop + lat);
                    chk("finish_code", o_finish_code, code);
                    chk("rsp_data", o_rsp_data, 0);
                    check_regs();
                    fprev = cyc;
                end
            end
            if (i_cmd_valid && o_cmd_ready) begin
                a.cmd = int'(i_cmd); a.ch = int'(i_cmd_ch); a.bc = i_cmd_bcast;
                a.param = i_cmd_param; a.push_cyc = cyc;
                acc_q.push_back(a);
            end
            if (i_cmd_valid && !o_cmd_ready) saw_stall = 1;
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_cmd(input int cmd, input int ch, input bit bc, input logic [31:0] p);
        bit ok;
        ok = 0;
        i_cmd = 16'(cmd); i_cmd_ch = 4'(ch); i_cmd_bcast = bc; i_cmd_param = p;
        i_cmd_valid = 1'b1;
        for (int t = 0; t < 2000; t++) begin
            @(negedge i_clk);
            if (o_cmd_ready) ok = 1;
            tick();
            if (ok) break;
        end
        i_cmd_valid = 1'b0;
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 20000; t++) begin
            if (acc_q.size() == 0) break;
            tick();
        end
        chk("drain", acc_q.size(), 0);
        tick();
    endtask

    // ---------------- stimulus ----------------
    int cmd_tab[10] = '{1, 2, 3, 4, 5, 5, 6, 0, 7, 8};

    initial begin
        int          c;
        int          sel;
        logic [15:0] f;
        logic [15:0] ns;
        logic [31:0] p;

        i_rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd = '0; i_cmd_ch = '0;
        i_cmd_bcast = 1'b0; i_cmd_param = '0;
        repeat (3) tick();
        i_rst_n = 1'b1;
        tick();

        // Reset state
        check_regs();
        chk("rst_finish", o_finish, 0);
        chk("rst_code", o_finish_code, 0);
        chk("rst_rsp", o_rsp_data, 0);
        chk("rst_ready", o_cmd_ready, 1);

        // 1000 Hz, 500 ns on ch1 -> 100000 / 50, both divisions
        push_cmd(5, 1, 0, 32'h01F4_03E8);
        wait_drain();
        chk("ch1_cycle", o_cycle[CYCLE_W +: CYCLE_W], 100000);
        chk("ch1_pulse", o_pulse[PULSE_W +: PULSE_W], 50);

        push_cmd(5, 0, 0, 32'h0000_0000);   // freq 0 -> status 3
        push_cmd(5, 2, 0, 32'h0000_0032);   // 50 Hz -> 2,000,000 overflows 20 bits
        push_cmd(1, 0, 1, 32'h0);           // broadcast start
        wait_drain();
        chk("bcast_run", o_run, 4'hF);
        push_cmd(2, 7, 0, 32'h0);           // channel out of range
        push_cmd(8, 0, 0, 32'h3);           // readback not built in
        wait_drain();
        chk("run_kept", o_run, 4'hF);

        // Back-to-back burst behind a FREQU fills the FIFO
        saw_stall = 0;
        push_cmd(5, 3, 0, 32'h0064_2710);
        push_cmd(3, 0, 0, 32'h1);
        push_cmd(4, 1, 0, 32'h1);
        push_cmd(6, 2, 0, 32'h0003_0100);
        push_cmd(2, 0, 1, 32'h0);
        push_cmd(7, 0, 0, 32'h0);
        wait_drain();
        chk("saw_stall", saw_stall, 1);

        // Random commands with random gaps
        for (int n = 0; n < 40; n++) begin
            c = cmd_tab[$urandom_range(0, 9)];
            p = $urandom;
            if (c == 5) begin
                sel = $urandom_range(0, 9);
                if (sel == 0)      f = 16'd0;
                else if (sel == 1) f = 16'($urandom_range(1, 99));
                else               f = 16'($urandom_range(100, 65535));
                sel = $urandom_range(0, 3);
                if (sel == 0)      ns = 16'd0;
                else if (sel == 1) ns = 16'($urandom_range(0, 65535));
                else               ns = 16'($urandom_range(10, 20000));
                p = {ns, f};
            end
            push_cmd(c, $urandom_range(0, 5), ($urandom_range(0, 5) == 0), p);
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_drain();

        // Reset while the cycle division is running
        push_cmd(5, 0, 0, 32'h01F4_03E8);
        push_cmd(1, 2, 0, 32'h0);
        repeat (10) tick();
        i_rst_n = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        check_regs();
        chk("mid_rst_finish", o_finish, 0);
        chk("mid_rst_code", o_finish_code, 0);
        chk("mid_rst_ready", o_cmd_ready, 1);
        repeat (100) tick();               // a lost command must not complete
        push_cmd(4, 2, 0, 32'h1);
        wait_drain();
        chk("post_rst_neg", o_outnegedge, 4'b0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cmd_dispatch.md
Name: cmd_dispatch

Overview:
Multi-channel successor to the single-channel trigger/acquisition command processor. Accepts host commands through a valid/ready handshake into a small command FIFO and decodes them one at a time. Updates per-channel run/trigger/wave/timing registers, computing cycle and pulse lengths with a shared sequential divider instead of combinational division. Reports completion with a status code; sits between the host interface (USB/Ethernet bridge) and NUM_CH pulser/acquisition channels.

Parameters:
NUM_CH, 4, number of pulser/acquisition channels (1..16)
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
CLK_HZ, 100000000, i_clk frequency; cycle = CLK_HZ / freq_hz
CYCLE_W, 20, width of each cycle register (10 ns units)
PULSE_W, 12, width of each pulse register (10 ns units)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_cmd_valid  in  1  command present (synchronous to i_clk)
o_cmd_ready  out  1  FIFO not full
i_cmd  in  16  command code
i_cmd_ch  in  4  target channel
i_cmd_bcast  in  1  apply to all channels, i_cmd_ch ignored
i_cmd_param  in  32  command parameter
o_run  out  NUM_CH  per-channel run enable
o_outmode  out  NUM_CH  per-channel trigger mode
o_outnegedge  out  NUM_CH  per-channel trigger edge
o_waveRawSize  out  NUM_CH*16  ch k at [16k+15:16k]
o_waveRate  out  NUM_CH*3  ch k at [3k+2:3k]
o_cycle  out  NUM_CH*CYCLE_W  per-channel period
o_pulse  out  NUM_CH*PULSE_W  per-channel pulse width
o_finish  out  1  one-cycle pulse per completed command
o_finish_code  out  16  status, valid with o_finish, held until next completion
o_rsp_data  out  32  readback data, valid with o_finish

Behaviour:
- Reset, every channel: run 0, outmode 0, outnegedge 0, waveRawSize 128, waveRate 1, cycle 100000, pulse 100; o_finish 0, o_finish_code 0, o_rsp_data 0, FIFO empty, FSM IDLE.
- Push on i_cmd_valid & o_cmd_ready. o_cmd_ready = !full. Push and pop may occur in the same cycle.
- Commands: 1 START_RUN, 2 STOP_RUN, 3 SET_TRIG_MODE (param[0]), 4 SET_TRIG_EDGE (param[0]), 5 SET_TRIG_FREQU (param[15:0] = Hz, param[31:16] = pulse ns), 6 SET_WAVE_SIZE ({rate, size} = param[18:0]), 8 READ_REG (optional feature only).
- FSM states: IDLE -> DECODE -> DIV_CYC -> DIV_PLS -> CHECK -> COMMIT -> DONE -> IDLE.
  - IDLE pops when the FIFO is non-empty.
  - Non-FREQU commands go DECODE -> COMMIT.
  - FREQU goes through DIV_CYC, then DIV_PLS (skipped when param[31:16] == 0; pulse unchanged), then CHECK.
- Divider: unsigned restoring, 32-bit, 1 quotient bit per cycle; done 33 cycles after start.
- Latency from pop cycle to o_finish high:
  - non-FREQU: 3 cycles.
  - FREQU: 3 + 33 + 33 cycles; 3 + 33 when the DIV_PLS step is skipped.
  - CHECK adds no cycle; it is combinational on the DIV_PLS exit.
- Status codes:
  - 0 OK
  - 1 unknown command
  - 2 channel >= NUM_CH (non-broadcast)
  - 3 freq == 0; divider not started, FREQU latency 3
  - 4 range: quotient > 2^CYCLE_W - 1, or pulse > 2^PULSE_W - 1, or pulse >= cycle
- Any nonzero status: no register changes. Broadcast writes all channels in the same cycle.
- Registers update in COMMIT; o_finish is asserted in DONE, one cycle later.
- Reset mid-operation: FSM, divider and FIFO cleared immediately; the pending command is lost and no o_finish is produced.
- New pushes during processing are queued; at most one command is in flight.

Optional Feature:
CMD_DISPATCH_READBACK_EN
- Defined: command 8 returns the selected channel's register into o_rsp_data, selected by param[2:0]: 0 {run, outmode, outnegedge}, 1 {rate, size}, 2 cycle, 3 pulse, zero-extended. Status 0; param[2:0] > 3 gives status 1.
- Undefined: command 8 gives status 1 and o_rsp_data stays 0.

Decomposition:
- Package cmd_dispatch_pkg:
  - command code constants.
  - status code constants.
  - FSM state enum.
  - reset-default constants.
- Sub-module seq_div:
  - ports: start, dividend[31:0], divisor[31:0], busy, done pulse, quotient[31:0].
- FIFO inline: pointer-based, one extra wrap bit.

Test Plan:
- Reset, then sample all outputs -> ch0..3 cycle=100000, pulse=100, waveRawSize=128, waveRate=1, run=0.
- Push cmd5 ch1, param=0x01F4_03E8 (500 ns, 1000 Hz) -> ch1 cycle=100000, pulse=50, code 0, o_finish exactly 69 cycles after pop; other channels unchanged.
- cmd5 param=0x0000_0000 -> code 3 after 3 cycles; cmd5 freq=50 Hz -> quotient 2000000 exceeds 20 bits, code 4, no change.
- cmd1 with bcast=1 -> o_run=4'b1111 in one cycle; cmd2 ch=7 (NUM_CH=4) -> code 2, o_run unchanged.
- Push 5 commands back-to-back with FIFO_DEPTH=4 during a FREQU -> ready deasserts when full; all accepted commands finish in order; no command is lost or duplicated.
- Assert reset mid-DIV_CYC -> all defaults restored, no o_finish, FIFO empty, next command executes normally.
